// File: rtl/issue_queue_agesel.sv
// Centralised issue queue: dispatch alloc, tag wakeup, age-matrix oldest-first select.
// Optional macro IQ_SPEC_WAKEUP_EN: selected producers also broadcast their prd.
module issue_queue_agesel #(
    parameter int DEPTH     = 16,
    parameter int DISP_NUM  = 4,
    parameter int ISSUE_NUM = 4,
    parameter int WB_NUM    = 4,
    parameter int OPCODE    = 7,
    parameter int PRF_WIDTH = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [DISP_NUM-1:0]            disp_valid,
    output logic                           disp_ready,
    input  logic [DISP_NUM*OPCODE-1:0]     disp_op,
    input  logic [DISP_NUM*PRF_WIDTH-1:0]  disp_prs1,
    input  logic [DISP_NUM*PRF_WIDTH-1:0]  disp_prs2,
    input  logic [DISP_NUM*PRF_WIDTH-1:0]  disp_prd,
    input  logic [DISP_NUM-1:0]            disp_prs1_v,
    input  logic [DISP_NUM-1:0]            disp_prs2_v,
    input  logic [DISP_NUM-1:0]            disp_prd_v,
    input  logic [DISP_NUM-1:0]            disp_prs1_rdy,
    input  logic [DISP_NUM-1:0]            disp_prs2_rdy,
    input  logic [WB_NUM-1:0]              wb_valid,
    input  logic [WB_NUM*PRF_WIDTH-1:0]    wb_tag,
    output logic [ISSUE_NUM-1:0]           iss_valid,
    output logic [ISSUE_NUM*OPCODE-1:0]    iss_op,
    output logic [ISSUE_NUM*PRF_WIDTH-1:0] iss_prs1,
    output logic [ISSUE_NUM*PRF_WIDTH-1:0] iss_prs2,
    output logic [ISSUE_NUM*PRF_WIDTH-1:0] iss_prd,
    output logic [ISSUE_NUM-1:0]           iss_prd_v,
    output logic [$clog2(DEPTH):0]         occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = IW + 1;
    localparam logic [OW-1:0] OCC_LIM = OW'(DEPTH - DISP_NUM);
`ifdef IQ_SPEC_WAKEUP_EN
    localparam int WK = WB_NUM + ISSUE_NUM;
`else
    localparam int WK = WB_NUM;
`endif

    logic [DEPTH-1:0]     valid_q;
    logic [OPCODE-1:0]    op_q   [DEPTH];
    logic [PRF_WIDTH-1:0] prs1_q [DEPTH];
    logic [PRF_WIDTH-1:0] prs2_q [DEPTH];
    logic [PRF_WIDTH-1:0] prd_q  [DEPTH];
    logic [DEPTH-1:0]     prs1_v_q, prs1_rdy_q;
    logic [DEPTH-1:0]     prs2_v_q, prs2_rdy_q;
    logic [DEPTH-1:0]     prd_v_q;
    logic [DEPTH-1:0]     older_q [DEPTH];
    logic [OW-1:0]        occ_q;

    logic [DISP_NUM-1:0]  acc;
    logic [IW-1:0]        alloc_idx [DISP_NUM];
    logic [DEPTH-1:0]     new_row [DISP_NUM];
    logic [ISSUE_NUM-1:0] sel_v;
    logic [IW-1:0]        sel_idx [ISSUE_NUM];
    logic [DEPTH-1:0]     sel_mask;
    logic [WK-1:0]        wk_v;
    logic [PRF_WIDTH-1:0] wk_tag [WK];
    logic [DEPTH-1:0]     e_hit1, e_hit2;
    logic [DISP_NUM-1:0]  d_hit1, d_hit2;
    logic [OW-1:0]        occ_d;

    assign disp_ready = occ_q <= OCC_LIM;
    assign occupancy  = occ_q;
    assign acc        = disp_valid & {DISP_NUM{disp_ready}};
    assign occ_d      = occ_q + OW'($countones(acc)) - OW'($countones(sel_v));

    // Slot i takes the i-th lowest free entry; it is younger than all live entries and lower slots.
    always_comb begin
        logic [DEPTH-1:0] prior;
        int n;
        n = 0;
        prior = '0;
        for (int i = 0; i < DISP_NUM; i++) begin
            alloc_idx[i] = '0;
            new_row[i]   = '0;
        end
        for (int e = 0; e < DEPTH; e++) begin
            if (!valid_q[e] && n < DISP_NUM) begin
                alloc_idx[n] = IW'(e);
                n = n + 1;
            end
        end
        for (int i = 0; i < DISP_NUM; i++) begin
            new_row[i] = valid_q | prior;
            if (acc[i])
                prior[alloc_idx[i]] = 1'b1;
        end
    end

    // An entry is oldest when no other remaining candidate is older than it.
    always_comb begin
        logic [DEPTH-1:0] left;
        left = valid_q & prs1_rdy_q & prs2_rdy_q;
        sel_mask = '0;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            sel_v[k]   = 1'b0;
            sel_idx[k] = '0;
            for (int e = 0; e < DEPTH; e++) begin
                if (!sel_v[k] && left[e] && ((older_q[e] & left) == '0)) begin
                    sel_v[k]   = 1'b1;
                    sel_idx[k] = IW'(e);
                end
            end
            if (sel_v[k]) begin
                left[sel_idx[k]]     = 1'b0;
                sel_mask[sel_idx[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int w = 0; w < WB_NUM; w++) begin
            wk_v[w]   = wb_valid[w];
            wk_tag[w] = wb_tag[w*PRF_WIDTH +: PRF_WIDTH];
        end
`ifdef IQ_SPEC_WAKEUP_EN
        for (int k = 0; k < ISSUE_NUM; k++) begin
            wk_v[WB_NUM+k]   = sel_v[k] & prd_v_q[sel_idx[k]];
            wk_tag[WB_NUM+k] = prd_q[sel_idx[k]];
        end
`endif
    end

    always_comb begin
        e_hit1 = '0;
        e_hit2 = '0;
        d_hit1 = '0;
        d_hit2 = '0;
        for (int w = 0; w < WK; w++) begin
            if (wk_v[w]) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (prs1_q[e] == wk_tag[w]) e_hit1[e] = 1'b1;
                    if (prs2_q[e] == wk_tag[w]) e_hit2[e] = 1'b1;
                end
                for (int i = 0; i < DISP_NUM; i++) begin
                    if (disp_prs1[i*PRF_WIDTH +: PRF_WIDTH] == wk_tag[w]) d_hit1[i] = 1'b1;
                    if (disp_prs2[i*PRF_WIDTH +: PRF_WIDTH] == wk_tag[w]) d_hit2[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            prs1_v_q   <= '0;
            prs1_rdy_q <= '0;
            prs2_v_q   <= '0;
            prs2_rdy_q <= '0;
            prd_v_q    <= '0;
            occ_q      <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                op_q[e]    <= '0;
                prs1_q[e]  <= '0;
                prs2_q[e]  <= '0;
                prd_q[e]   <= '0;
                older_q[e] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_q & ~sel_mask;
            for (int e = 0; e < DEPTH; e++) begin
                if (valid_q[e] && prs1_v_q[e] && e_hit1[e]) prs1_rdy_q[e] <= 1'b1;
                if (valid_q[e] && prs2_v_q[e] && e_hit2[e]) prs2_rdy_q[e] <= 1'b1;
            end
            for (int i = 0; i < DISP_NUM; i++) begin
                if (acc[i])
                    for (int j = 0; j < DEPTH; j++)
                        older_q[j][alloc_idx[i]] <= 1'b0;
            end
            for (int i = 0; i < DISP_NUM; i++) begin
                if (acc[i]) begin
                    valid_q[alloc_idx[i]]    <= 1'b1;
                    op_q[alloc_idx[i]]       <= disp_op[i*OPCODE +: OPCODE];
                    prs1_q[alloc_idx[i]]     <= disp_prs1[i*PRF_WIDTH +: PRF_WIDTH];
                    prs2_q[alloc_idx[i]]     <= disp_prs2[i*PRF_WIDTH +: PRF_WIDTH];
                    prd_q[alloc_idx[i]]      <= disp_prd[i*PRF_WIDTH +: PRF_WIDTH];
                    prs1_v_q[alloc_idx[i]]   <= disp_prs1_v[i];
                    prs2_v_q[alloc_idx[i]]   <= disp_prs2_v[i];
                    prd_v_q[alloc_idx[i]]    <= disp_prd_v[i];
                    prs1_rdy_q[alloc_idx[i]] <= disp_prs1_rdy[i] | ~disp_prs1_v[i] | d_hit1[i];
                    prs2_rdy_q[alloc_idx[i]] <= disp_prs2_rdy[i] | ~disp_prs2_v[i] | d_hit2[i];
                    older_q[alloc_idx[i]]    <= new_row[i];
                end
            end
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid <= '0;
            iss_op    <= '0;
            iss_prs1  <= '0;
            iss_prs2  <= '0;
            iss_prd   <= '0;
            iss_prd_v <= '0;
        end else if (flush) begin
            iss_valid <= '0;
            iss_op    <= '0;
            iss_prs1  <= '0;
            iss_prs2  <= '0;
            iss_prd   <= '0;
            iss_prd_v <= '0;
        end else begin
            for (int k = 0; k < ISSUE_NUM; k++) begin
                iss_valid[k] <= sel_v[k];
                iss_op[k*OPCODE +: OPCODE] <=
                    sel_v[k] ? op_q[sel_idx[k]] : '0;
                iss_prs1[k*PRF_WIDTH +: PRF_WIDTH] <=
                    sel_v[k] ? prs1_q[sel_idx[k]] : '0;
                iss_prs2[k*PRF_WIDTH +: PRF_WIDTH] <=
                    sel_v[k] ? prs2_q[sel_idx[k]] : '0;
                iss_prd[k*PRF_WIDTH +: PRF_WIDTH] <=
                    sel_v[k] ? prd_q[sel_idx[k]] : '0;
                iss_prd_v[k] <= sel_v[k] & prd_v_q[sel_idx[k]];
            end
        end
    end
endmodule

// File: doc/issue_queue_agesel.md
Name: issue_queue_agesel

Overview:
- Parametrised centralised issue queue, successor to the 16-entry CIQ.
- Sits between rename/dispatch and the execute ports.
- Owns its free-entry allocation, tag-broadcast wakeup, oldest-first multi-port select, issue-port output registers and pipeline flush. No external allocator or arbiter is needed.

Parameters:
- DEPTH, 16, number of queue entries (power of two, >= DISP_NUM)
- DISP_NUM, 4, dispatch slots per cycle
- ISSUE_NUM, 4, issue ports per cycle
- WB_NUM, 4, wakeup tag broadcast ports
- OPCODE, 7, opcode width
- PRF_WIDTH, 6, physical register tag width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all entries and issue registers
- disp_valid  in  DISP_NUM  per-slot dispatch request; slots must be packed low (slot i valid implies slot i-1 valid)
- disp_ready  out  1  queue can accept DISP_NUM instructions this cycle
- disp_op  in  DISP_NUM*OPCODE  opcodes, slot i at [i*OPCODE +: OPCODE]
- disp_prs1, disp_prs2, disp_prd  in  DISP_NUM*PRF_WIDTH each  source and destination tags
- disp_prs1_v, disp_prs2_v, disp_prd_v  in  DISP_NUM each  operand/destination present
- disp_prs1_rdy, disp_prs2_rdy  in  DISP_NUM each  operand ready at rename
- wb_valid  in  WB_NUM  wakeup broadcast valid
- wb_tag  in  WB_NUM*PRF_WIDTH  broadcast destination tags
- iss_valid  out  ISSUE_NUM  registered issue valid
- iss_op  out  ISSUE_NUM*OPCODE  issued opcode
- iss_prs1, iss_prs2, iss_prd  out  ISSUE_NUM*PRF_WIDTH each  issued tags
- iss_prd_v  out  ISSUE_NUM  issued destination present
- occupancy  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:

Reset (rst_n low, asynchronous):
- All entries invalid; age matrix cleared.
- iss_valid=0 and all iss_* payloads=0; occupancy=0; disp_ready=1.

Entry state:
- Fields: valid, op, prs1/prs2 tag+v+rdy, prd tag+v.
- Plus a DEPTH x DEPTH age matrix: older[i][j]=1 means entry j is older than entry i.

Dispatch:
- disp_ready = (DEPTH - occupancy) >= DISP_NUM. It is combinational from registered state only.
- A slot is accepted when disp_valid[i] & disp_ready.
- Slot i is written to the i-th lowest-index free entry at the clock edge.
- Age: a new entry is younger than all currently valid entries. Among same-cycle slots, a lower slot index is older.
- Operand ready = disp_prsX_rdy | ~disp_prsX_v | a match with any wb_valid/wb_tag in the same cycle (same-cycle bypass).
- disp_valid while disp_ready=0: ignored, no state change.

Wakeup:
- Each cycle, every valid entry with v=1 and a tag equal to any valid wb_tag sets its rdy bit at the edge.
- rdy never clears while the entry lives.

Select:
- Combinational on registered state.
- Candidates: valid & prs1_rdy & prs2_rdy.
- Port 0 takes the oldest candidate. Port k takes the oldest candidate not taken by ports 0..k-1.
- Fewer candidates than ISSUE_NUM leaves the upper ports idle.

Issue:
- Selected payloads are registered into iss_* at the edge; the selected entries are invalidated at the same edge.
- The issue registers load every cycle, so iss_valid is a one-cycle pulse per instruction. There is no issue back-pressure.

Latency and occupancy:
- An instruction dispatched ready in cycle t has iss_valid high in cycle t+2 at the earliest.
- A wakeup in cycle t allows issue visible in cycle t+2.
- occupancy is updated the same edge as issue and dispatch: occ + accepted - issued. A freed entry is not reusable until the next cycle.

Flush:
- Has priority over dispatch, wakeup and issue.
- Next cycle: all entries invalid, iss_valid=0, occupancy=0.
- Asynchronous reset mid-operation behaves identically and is immediate.

Boundaries:
- Full queue: disp_ready=0. The same cycle an issue frees entries, disp_ready still reflects the old occupancy.
- Duplicate wb_tags are harmless.
- A tag of 0 is treated like any other tag.

Optional Feature:
- Macro IQ_SPEC_WAKEUP_EN.
- When defined: each selected entry with prd_v=1 also broadcasts its prd as a wakeup in the same cycle it is selected, merged with wb_*. This allows back-to-back issue of a dependent instruction (producer in cycle t+2, consumer in cycle t+3).
- When undefined: only wb_* wakes entries, and dependents wait for external writeback.

Test Plan:
- Reset, then dispatch 4 instructions with all operands ready -> disp_ready=1; 2 cycles later iss_valid=4'b1111, with the oldest (slot 0) on port 0; occupancy returns to 0.
- Dispatch 16 not-ready instructions over 4 cycles -> occupancy=16, disp_ready=0; further disp_valid ignored; wb_tag of one prs1 (other operand absent) -> that instruction issues on port 0 two cycles later, and disp_ready stays 0 until occupancy<=12.
- Dispatch A (prs1=5, not ready) while wb_tag=5 in the same cycle -> A issues at t+2 (bypass captured).
- 6 ready entries of mixed age -> ports 0-3 get the 4 oldest in age order; the remaining 2 issue next cycle.
- flush asserted with 10 entries and iss_valid active -> next cycle iss_valid=0, occupancy=0; rst_n pulsed low mid-dispatch -> outputs cleared immediately.
- With IQ_SPEC_WAKEUP_EN: producer prd=9 and consumer prs1=9 -> consumer iss_valid exactly one cycle after the producer. Without it: consumer waits for wb_tag=9.
